// File: rtl/sd_sector_streamer.sv
// Streams a run of consecutive SD sectors from sd_controller into a byte FIFO and out as valid/ready.
// Latency: a captured byte appears on m_data_o one cycle after its sd_byte_available_i pulse.
// Backpressure: the consumer may stall freely; a sector is requested only when 512 bytes of FIFO space are free.
module sd_sector_streamer #(
    parameter int FIFO_DEPTH = 1024,
    parameter bit BLOCK_ADDR = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [31:0] start_sector_i,
    input  logic [15:0] num_sectors_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        overflow_o,
    input  logic        sd_ready_i,
    output logic        sd_rd_o,
    output logic [31:0] sd_address_o,
    input  logic [7:0]  sd_dout_i,
    input  logic        sd_byte_available_i,
    output logic [7:0]  m_data_o,
    output logic        m_valid_o,
    input  logic        m_ready_i
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
    // Highest fill level that still leaves room for one complete sector.
    localparam logic [AW:0] ROOM_LIMIT = (AW+1)'(FIFO_DEPTH - 512);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_RECV,
        S_WAIT_CRC
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cur_sector_q, cur_sector_d;
    logic [15:0] remaining_q, remaining_d;
    logic [9:0]  byte_cnt_q, byte_cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        overflow_q, overflow_d;
    logic        sd_rd_q, sd_rd_d;
    logic [31:0] sd_address_q, sd_address_d;

    // FIFO storage and pointers; the extra pointer bit separates full from empty.
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0] fill;
    logic        fifo_empty, fifo_full, room_ok;
    logic        byte_in, push, pop, drop;

    assign fill       = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (fill == '0);
    assign fifo_full  = (fill == DEPTH_CNT);
    assign room_ok    = (fill <= ROOM_LIMIT);

    // Bytes are only captured while a sector is being received; anything else is noise.
    assign byte_in = (state_q == S_RECV) && sd_byte_available_i;
    // Popping an empty FIFO is impossible since m_valid_o is low then.
    assign pop     = !fifo_empty && m_ready_i;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push    = byte_in && (!fifo_full || pop);
    assign drop    = byte_in && fifo_full && !pop;

    // FIFO data array: written only, never reset, so it maps onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= sd_dout_i;
        end
    end

    // FIFO pointers; reset empties the FIFO.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // First-word-fall-through head; forced to zero while empty so reset shows m_data_o = 0.
    assign m_valid_o = !fifo_empty;
    assign m_data_o  = fifo_empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            cur_sector_q <= '0;
            remaining_q  <= '0;
            byte_cnt_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            sd_rd_q      <= 1'b0;
            sd_address_q <= '0;
        end else begin
            state_q      <= state_d;
            cur_sector_q <= cur_sector_d;
            remaining_q  <= remaining_d;
            byte_cnt_q   <= byte_cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
            sd_rd_q      <= sd_rd_d;
            sd_address_q <= sd_address_d;
        end
    end

    // Next-state logic for the sector sequencer.
    always_comb begin
        state_d      = state_q;
        cur_sector_d = cur_sector_q;
        remaining_d  = remaining_q;
        byte_cnt_d   = byte_cnt_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        overflow_d   = overflow_q | drop;
        sd_rd_d      = 1'b0;
        sd_address_d = sd_address_q;

        case (state_q)
            S_IDLE: begin
                // The done cycle also sits in S_IDLE; a start there is ignored.
                if (start_i && !done_q) begin
                    overflow_d = 1'b0;
                    if (num_sectors_i == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        cur_sector_d = start_sector_i;
                        remaining_d  = num_sectors_i;
                        busy_d       = 1'b1;
                        state_d      = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                // The card cannot be paused mid-sector, so reserve a whole sector first.
                if (sd_ready_i && room_ok) begin
                    sd_rd_d      = 1'b1;
                    sd_address_d = BLOCK_ADDR ? cur_sector_q : {cur_sector_q[22:0], 9'b0};
                    state_d      = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (!sd_ready_i) begin
                    byte_cnt_d = '0;
                    state_d    = S_RECV;
                end
            end
            S_RECV: begin
                if (sd_byte_available_i) begin
                    byte_cnt_d = byte_cnt_q + 10'd1;
                    if (byte_cnt_q == 10'd511) begin
                        state_d = S_WAIT_CRC;
                    end
                end
            end
            S_WAIT_CRC: begin
                // sd_controller raises ready again once the CRC bytes are consumed.
                if (sd_ready_i) begin
                    cur_sector_d = cur_sector_q + 32'd1;
                    remaining_d  = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign overflow_o   = overflow_q;
    assign sd_rd_o      = sd_rd_q;
    assign sd_address_o = sd_address_q;

endmodule

// File: tb/tb_sd_sector_streamer.sv
module tb_sd_sector_streamer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] start_sector;
    logic [15:0] num_sectors;
    logic        sd_ready;
    logic [7:0]  sd_dout;
    logic        sd_byte_av;
    logic        m_ready;

    logic        busy0, done0, ovf0, rd0, mvalid0;
    logic [31:0] addr0;
    logic [7:0]  mdata0;
    logic        busy1, done1, ovf1, rd1, mvalid1;
    logic [31:0] addr1;
    logic [7:0]  mdata1;

    int vectors = 0;
    int miscompares = 0;

    // Monitor / card bookkeeping
    int          card_idx = 0;
    int          rd_cnt, done_cnt, pop_cnt, data_err;
    logic        busy_seen;
    logic [31:0] rd_addr0 [8];
    logic [31:0] rd_addr1 [8];
    int          pops_at_rd [8];

    initial forever #5 clk = ~clk;

    sd_sector_streamer #(.FIFO_DEPTH(1024), .BLOCK_ADDR(1'b1)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .start_sector_i(start_sector),
        .num_sectors_i(num_sectors), .busy_o(busy0), .done_o(done0), .overflow_o(ovf0),
        .sd_ready_i(sd_ready), .sd_rd_o(rd0), .sd_address_o(addr0), .sd_dout_i(sd_dout),
        .sd_byte_available_i(sd_byte_av), .m_data_o(mdata0), .m_valid_o(mvalid0),
        .m_ready_i(m_ready)
    );

    // Byte-addressed twin: sees identical inputs, so it tracks the first instance cycle for cycle.
    sd_sector_streamer #(.FIFO_DEPTH(1024), .BLOCK_ADDR(1'b0)) u_dut_byte (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .start_sector_i(start_sector),
        .num_sectors_i(num_sectors), .busy_o(busy1), .done_o(done1), .overflow_o(ovf1),
        .sd_ready_i(sd_ready), .sd_rd_o(rd1), .sd_address_o(addr1), .sd_dout_i(sd_dout),
        .sd_byte_available_i(sd_byte_av), .m_data_o(mdata1), .m_valid_o(mvalid1),
        .m_ready_i(m_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Card model: after rd, drop ready, deliver 512 bytes (one every other cycle), CRC gap, raise ready.
    initial begin
        sd_ready   = 1'b1;
        sd_byte_av = 1'b0;
        sd_dout    = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n && rd0) begin
                sd_ready = 1'b0;
                repeat (3) @(negedge clk);
                for (int b = 0; b < 512; b++) begin
                    if (!rst_n) break;
                    sd_dout    = card_idx[7:0];
                    sd_byte_av = 1'b1;
                    card_idx++;
                    @(negedge clk);
                    sd_byte_av = 1'b0;
                    @(negedge clk);
                end
                sd_byte_av = 1'b0;
                if (rst_n) repeat (4) @(negedge clk);
                sd_ready = 1'b1;
            end
        end
    end

    // Observe rd pulses, done pulses and accepted stream bytes.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd0) begin
                if (rd_cnt < 8) begin
                    rd_addr0[rd_cnt]   = addr0;
                    rd_addr1[rd_cnt]   = addr1;
                    pops_at_rd[rd_cnt] = pop_cnt;
                end
                rd_cnt++;
            end
            if (done0) done_cnt++;
            if (busy0) busy_seen = 1'b1;
            if (mvalid0 && m_ready) begin
                if (mdata0 !== pop_cnt[7:0]) data_err++;
                pop_cnt++;
            end
        end
    end

    task automatic clear_stats();
        rd_cnt    = 0;
        done_cnt  = 0;
        pop_cnt   = 0;
        data_err  = 0;
        card_idx  = 0;
        busy_seen = 1'b0;
    endtask

    task automatic do_start(input logic [31:0] sec, input logic [15:0] n);
        @(negedge clk);
        start_sector = sec;
        num_sectors  = n;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        for (int i = 0; i < max_cyc && done_cnt == 0; i++) @(negedge clk);
    endtask

    task automatic wait_pops(input int n, input int max_cyc);
        for (int i = 0; i < max_cyc && pop_cnt < n; i++) @(negedge clk);
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        start_sector = '0;
        num_sectors  = '0;
        m_ready      = 1'b1;
        clear_stats();
        #1;
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_ovf", ovf0, 0);
        chk("rst_rd", rd0, 0);
        chk("rst_addr", addr0, 0);
        chk("rst_mvalid", mvalid0, 0);
        chk("rst_mdata", mdata0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Two sectors, block addressing, free-running consumer.
        clear_stats();
        do_start(32'h10, 16'd2);
        wait_done(5000);
        wait_pops(1024, 200);
        repeat (3) @(negedge clk);
        chk("t1_rd_cnt", rd_cnt, 2);
        chk("t1_addr0", rd_addr0[0], 32'h10);
        chk("t1_addr1", rd_addr0[1], 32'h11);
        chk("t1_byteaddr0", rd_addr1[0], 32'h2000);
        chk("t1_pops", pop_cnt, 1024);
        chk("t1_data_err", data_err, 0);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_ovf", ovf0, 0);
        chk("t1_busy", busy0, 0);

        // One sector at sector 3: byte-addressed instance must present 3*512.
        clear_stats();
        do_start(32'h3, 16'd1);
        wait_done(3000);
        wait_pops(512, 200);
        chk("t2_rd_cnt", rd_cnt, 1);
        chk("t2_blk_addr", rd_addr0[0], 32'h3);
        chk("t2_byte_addr", rd_addr1[0], 32'h600);
        chk("t2_pops", pop_cnt, 512);

        // Stalled consumer: only two sectors fit, third waits for 512 pops.
        clear_stats();
        m_ready = 1'b0;
        do_start(32'h20, 16'd3);
        for (int i = 0; i < 4000 && !(card_idx >= 1024 && sd_ready); i++) @(negedge clk);
        repeat (60) @(negedge clk);
        chk("t3_rd_stalled", rd_cnt, 2);
        chk("t3_busy", busy0, 1);
        chk("t3_mvalid", mvalid0, 1);
        chk("t3_head_held", mdata0, 8'h00);
        m_ready = 1'b1;
        wait_done(6000);
        wait_pops(1536, 1500);
        chk("t3_rd_cnt", rd_cnt, 3);
        chk("t3_rd3_after_pops", (pops_at_rd[2] >= 512) ? 1 : 0, 1);
        chk("t3_pops", pop_cnt, 1536);
        chk("t3_data_err", data_err, 0);
        chk("t3_ovf", ovf0, 0);

        // Zero sectors; start during the done cycle is ignored, start one cycle later is taken.
        clear_stats();
        @(negedge clk);
        start_sector = 32'h55;
        num_sectors  = 16'd0;
        start        = 1'b1;
        @(negedge clk);
        chk("t4_done_next", done0, 1);
        chk("t4_busy", busy0, 0);
        @(negedge clk);
        chk("t4_done_ignored", done0, 0);
        @(negedge clk);
        start = 1'b0;
        chk("t4_done_again", done0, 1);
        @(negedge clk);
        chk("t4_done_end", done0, 0);
        repeat (5) @(negedge clk);
        chk("t4_no_rd", rd_cnt, 0);
        chk("t4_busy_seen", busy_seen, 0);

        // Sector number wrap.
        clear_stats();
        do_start(32'hFFFF_FFFF, 16'd2);
        wait_done(5000);
        wait_pops(1024, 200);
        chk("t5_addr0", rd_addr0[0], 32'hFFFF_FFFF);
        chk("t5_addr1", rd_addr0[1], 32'h0000_0000);
        chk("t5_byteaddr0", rd_addr1[0], 32'hFFFF_FE00);
        chk("t5_byteaddr1", rd_addr1[1], 32'h0000_0000);
        chk("t5_data_err", data_err, 0);

        // Asynchronous reset in the middle of a sector.
        clear_stats();
        do_start(32'h5, 16'd1);
        for (int i = 0; i < 2000 && card_idx < 200; i++) @(negedge clk);
        chk("t6_reached_200", (card_idx >= 200) ? 1 : 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", busy0, 0);
        chk("t6_rst_rd", rd0, 0);
        chk("t6_rst_mvalid", mvalid0, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        clear_stats();
        do_start(32'h7, 16'd1);
        wait_done(3000);
        wait_pops(512, 200);
        chk("t6_rd_cnt", rd_cnt, 1);
        chk("t6_addr", rd_addr0[0], 32'h7);
        chk("t6_pops", pop_cnt, 512);
        chk("t6_data_err", data_err, 0);
        chk("t6_done_cnt", done_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sd_sector_streamer.md
Name: sd_sector_streamer

Overview:
- Sits directly downstream of sd_controller on the read path and feeds the video pipeline.
- Reads a run of consecutive 512-byte sectors from the SD card by issuing rd requests to sd_controller.
- Captures each byte presented on sd_controller's dout/byte_available into an internal FIFO.
- Delivers the bytes as a valid/ready byte stream that the consumer may stall.

Parameters:
- FIFO_DEPTH, 1024: FIFO depth in bytes; power of two, minimum 512.
- BLOCK_ADDR, 1: 1 = sd_address is the sector number (SDHC); 0 = sd_address is sector×512 (byte addressing).

Ports:
- clk  in  1  system clock (25 MHz, same clock as sd_controller).
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a run; ignored while busy.
- start_sector  in  32  first sector number; sampled when start is accepted.
- num_sectors  in  16  number of sectors to read; sampled when start is accepted.
- busy  out  1  high from start acceptance until the done pulse.
- done  out  1  one-cycle pulse after the last sector's CRC phase completes.
- overflow  out  1  sticky flag: a byte arrived while the FIFO was full. Cleared by reset or by an accepted start.
- sd_ready  in  1  connects to sd_controller ready.
- sd_rd  out  1  connects to sd_controller rd.
- sd_address  out  32  connects to sd_controller address.
- sd_dout  in  8  connects to sd_controller dout.
- sd_byte_available  in  1  connects to sd_controller byte_available; one-cycle pulse per byte.
- m_data  out  8  stream data.
- m_valid  out  1  stream data valid.
- m_ready  in  1  consumer accepts the byte when m_valid and m_ready are both high.

Behaviour:
- Reset (asynchronous, active-low):
  - Outputs: busy=0, done=0, overflow=0, sd_rd=0, sd_address=0, m_valid=0, m_data=0.
  - FIFO is emptied; state is S_IDLE.
  - Reset mid-run abandons the run immediately; sd_controller has its own reset.
- S_IDLE:
  - On start with num_sectors=0: done pulses on the next cycle, busy stays 0, no sd_rd is issued.
  - On start with num_sectors>0: latch cur_sector=start_sector and remaining=num_sectors, set busy=1, clear overflow, go to S_ISSUE.
- S_ISSUE:
  - Waits until sd_ready=1 and FIFO free space ≥512. The sd_controller cannot stall mid-sector, so a whole sector is always reserved before issuing.
  - Then drives sd_rd=1 for exactly one cycle with sd_address valid in that same cycle:
    - BLOCK_ADDR=1: sd_address = cur_sector.
    - BLOCK_ADDR=0: sd_address = {cur_sector[22:0], 9'b0}.
  - Goes to S_WAIT_ACK.
- S_WAIT_ACK:
  - Holds sd_address stable and waits for sd_ready=0.
  - On sd_ready=0: byte_cnt=0, go to S_RECV.
- S_RECV:
  - Each cycle with sd_byte_available=1: write sd_dout into the FIFO and increment byte_cnt (10 bits).
  - If the FIFO is full on a write, drop the byte and set overflow=1. By construction this must never happen.
  - When byte_cnt reaches 512, go to S_WAIT_CRC.
  - Bytes seen outside S_RECV are ignored.
- S_WAIT_CRC:
  - Waits for sd_ready=1 (sd_controller finished the CRC and returned to IDLE).
  - Then cur_sector = cur_sector+1 (wraps modulo 2^32) and remaining = remaining−1.
  - If remaining was 1: done=1 for one cycle, busy=0, go to S_IDLE. Otherwise go to S_ISSUE.
- done does not wait for the FIFO to drain; the stream may still be outputting bytes after done.
- FIFO:
  - Synchronous, first-word-fall-through. m_valid = !empty and m_data = head entry.
  - Write-to-m_valid latency is 1 cycle.
  - Simultaneous push and pop when full or empty is legal; the count is unchanged except when empty, where the pop is suppressed.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
- m_data is held stable while m_valid=1 and m_ready=0.
- start is ignored while busy=1, including in the done cycle. A start one cycle after done is accepted.

Test Plan:
- start_sector=0x10, num_sectors=2, BLOCK_ADDR=1, card model returns bytes i mod 256, m_ready=1 → sd_rd pulses twice with sd_address 0x10 then 0x11; 1024 bytes stream out in order; single done pulse; overflow=0.
- BLOCK_ADDR=0, start_sector=3, num_sectors=1 → sd_address=0x600 during the sd_rd cycle.
- FIFO_DEPTH=1024, m_ready=0, num_sectors=3 → exactly 2 sd_rd pulses issued; third is issued only after ≥512 bytes are popped; all 1536 bytes arrive intact; overflow=0.
- num_sectors=0 → done pulses one cycle after start; sd_rd never asserted; busy stays 0.
- start_sector=0xFFFFFFFF, num_sectors=2 → addresses 0xFFFFFFFF then 0x00000000.
- Async reset asserted mid-S_RECV (byte 200) → sd_rd, busy, m_valid go 0 immediately; a new start after reset release runs a clean sector.
